// File: rtl/sad_ctrl_pkg.sv
// Shared types and constants for the SAD attention sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package sad_ctrl_pkg;

  localparam int LD_LEN = 64;   // cycles per weight-load phase (8x8 matrix)
  localparam int DIM    = 8;    // embedding dimension
  localparam int CNT_W  = 8;    // phase counter width

  localparam logic [3:0] T_MIN = 4'd1;
  localparam logic [3:0] T_MID = 4'd4;
  localparam logic [3:0] T_MAX = 4'd8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_Q = 3'd1,
    LD_K = 3'd2,
    LD_V = 3'd3,
    QK   = 3'd4,
    SV   = 3'd5,
    OUT  = 3'd6
  } phase_t;

  function automatic logic t_legal(input logic [3:0] t);
    return (t == T_MIN) || (t == T_MID) || (t == T_MAX);
  endfunction

  // Number of cycles spent in phase p for token count t.
  function automatic logic [CNT_W-1:0] len_of(input phase_t p, input logic [3:0] t);
    logic [CNT_W-1:0] tw;
    tw = {{(CNT_W-4){1'b0}}, t};
    case (p)
      LD_Q, LD_K, LD_V: len_of = CNT_W'(LD_LEN);
      QK:               len_of = tw * tw;
      SV, OUT:          len_of = tw * CNT_W'(DIM);
      default:          len_of = '0;
    endcase
  endfunction

  // Fixed phase order of one task.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      LD_Q:    next_phase = LD_K;
      LD_K:    next_phase = LD_V;
      LD_V:    next_phase = QK;
      QK:      next_phase = SV;
      SV:      next_phase = OUT;
      default: next_phase = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sad_cg_gen.sv
// Maps the phase being entered to per-bank clock enables.
// Latency: combinational; the parent registers the outputs.
// Backpressure: none; cg_en=0 forces every enable high.
module sad_cg_gen
  import sad_ctrl_pkg::*;
(
  input  phase_t phase,
  input  logic   x_win,
  input  logic   cg_en,
  output logic   gate_x,
  output logic   gate_q,
  output logic   gate_k,
  output logic   gate_v,
  output logic   gate_s
);

  // A bank is clocked only in the phase that writes it, or always when gating is off.
  always_comb begin
    gate_x = ~cg_en | x_win;
    gate_q = ~cg_en | (phase == LD_Q);
    gate_k = ~cg_en | (phase == LD_K);
    gate_v = ~cg_en | (phase == LD_V);
    gate_s = ~cg_en | (phase == QK);
  end

endmodule

// File: rtl/sad_seq_ctrl.sv
// Sequencer: 192-cycle load burst (LD_Q/LD_K/LD_V), then QK, SV, OUT row emission.
// Latency: outputs registered; cycle n's outputs appear right after the edge sampling cycle n's in_valid.
// Backpressure: none; a dropped burst aborts to IDLE, in_valid while computing is ignored and flagged.
module sad_seq_ctrl
  import sad_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cg_en,
  input  logic       in_valid,
  input  logic [3:0] T,
  output logic       busy,
  output phase_t     phase,
  output logic [2:0] row_idx,
  output logic [2:0] col_idx,
  output logic       mac_clr,
  output logic       mac_en,
  output logic       gate_x,
  output logic       gate_q,
  output logic       gate_k,
  output logic       gate_v,
  output logic       gate_s,
  output logic       out_valid,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  phase_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [3:0]       t_reg, nxt_t;
  logic             drop_q, err_pend;
  logic             start, drop_d, pend_d;
  logic [2:0]       nxt_row, nxt_col;
  logic             nxt_clr, nxt_en, nxt_ov, x_win;
  logic             g_x, g_q, g_k, g_v, g_s;

  // Phase walk: start on in_valid from IDLE (or straight out of OUT), advance at cnt==len-1,
  // and fall back to IDLE one cycle after a dropped load burst.
  always_comb begin
    start     = 1'b0;
    nxt_state = state;
    nxt_cnt   = cnt + CNT_ONE;
    nxt_t     = t_reg;
    if (drop_q) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end else if (state == IDLE) begin
      nxt_cnt = '0;
      start   = in_valid;
    end else if (cnt == len_of(state, t_reg) - CNT_ONE) begin
      nxt_state = next_phase(state);
      nxt_cnt   = '0;
      start     = (state == OUT) && in_valid;
    end
    if (start) begin
      nxt_state = LD_Q;
      nxt_cnt   = '0;
      nxt_t     = t_legal(T) ? T : T_MAX;
    end
  end

  // Protocol errors are detected in the cycle they occur and reported one cycle later.
  always_comb begin
    drop_d = !in_valid && (nxt_state inside {LD_Q, LD_K, LD_V});
    pend_d = drop_d
           || (in_valid && (nxt_state inside {QK, SV, OUT}))
           || (start && !t_legal(T));
  end

  // Row/column indices and MAC controls for the phase being entered.
  always_comb begin
    nxt_row = nxt_cnt[5:3];
    nxt_col = nxt_cnt[2:0];
    nxt_clr = 1'b0;
    nxt_en  = 1'b0;
    nxt_ov  = 1'b0;
    case (nxt_state)
      QK: begin
        nxt_en = 1'b1;
        if (nxt_t == T_MID) begin
          nxt_row = {1'b0, nxt_cnt[3:2]};
          nxt_col = {1'b0, nxt_cnt[1:0]};
        end else if (nxt_t == T_MIN) begin
          nxt_row = '0;
          nxt_col = '0;
        end
        nxt_clr = (nxt_col == 3'd0);
      end
      SV: begin
        nxt_en  = 1'b1;
        nxt_clr = (nxt_col == 3'd0);
      end
      OUT:     nxt_ov = 1'b1;
      default: ;
    endcase
  end

  // X bank only captures the first T rows of the Q load.
  assign x_win = (nxt_state == LD_Q) && (nxt_cnt < {1'b0, nxt_t, 3'b000});

  sad_cg_gen u_cg (
    .phase  (nxt_state),
    .x_win  (x_win),
    .cg_en  (cg_en),
    .gate_x (g_x),
    .gate_q (g_q),
    .gate_k (g_k),
    .gate_v (g_v),
    .gate_s (g_s)
  );

  // Sequencer state, phase counter and latched token count.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      t_reg    <= '0;
      drop_q   <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      t_reg    <= nxt_t;
      drop_q   <= drop_d;
      err_pend <= pend_d;
    end
  end

  // Registered outputs; gates follow cg_en even while held in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      phase     <= IDLE;
      busy      <= 1'b0;
      row_idx   <= '0;
      col_idx   <= '0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      gate_x    <= ~cg_en;
      gate_q    <= ~cg_en;
      gate_k    <= ~cg_en;
      gate_v    <= ~cg_en;
      gate_s    <= ~cg_en;
    end else begin
      phase     <= nxt_state;
      busy      <= (nxt_state != IDLE);
      row_idx   <= nxt_row;
      col_idx   <= nxt_col;
      mac_clr   <= nxt_clr;
      mac_en    <= nxt_en;
      out_valid <= nxt_ov;
      err       <= err_pend;
      gate_x    <= g_x;
      gate_q    <= g_q;
      gate_k    <= g_k;
      gate_v    <= g_v;
      gate_s    <= g_s;
    end
  end

endmodule

// File: tb/tb_sad_seq_ctrl.sv
// Directed bench for sad_seq_ctrl: per-task activity windows and index spot values.
// Latency: cycle n inputs are applied before edge n, outputs sampled 1 time unit after it.
// Backpressure: n/a.
module tb_sad_seq_ctrl;
  import sad_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, cg_en, in_valid;
  logic [3:0] T;
  logic       busy;
  phase_t     phase;
  logic [2:0] row_idx, col_idx;
  logic       mac_clr, mac_en, gate_x, gate_q, gate_k, gate_v, gate_s, out_valid, err;

  sad_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cg_en(cg_en), .in_valid(in_valid), .T(T),
    .busy(busy), .phase(phase), .row_idx(row_idx), .col_idx(col_idx),
    .mac_clr(mac_clr), .mac_en(mac_en),
    .gate_x(gate_x), .gate_q(gate_q), .gate_k(gate_k), .gate_v(gate_v), .gate_s(gate_s),
    .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  // signal slots: 0 ov, 1 busy, 2 err, 3 gx, 4 gq, 5 gk, 6 gv, 7 gs, 8 mac_en, 9 mac_clr, 10 QK, 11 SV
  int         n_chk = 0;
  int         n_pass = 0;
  int         first_a[12];
  int         last_a[12];
  int         cnt_a[12];
  string      nm[12] = '{"out_valid", "busy", "err", "gate_x", "gate_q", "gate_k",
                         "gate_v", "gate_s", "mac_en", "mac_clr", "ph_qk", "ph_sv"};
  phase_t     ph_a[400];
  logic [2:0] row_a[400];
  logic [2:0] col_a[400];
  logic [11:0] bits_a[400];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic sample(input int n);
    logic [11:0] b;
    b = {phase == SV, phase == QK, mac_clr, mac_en, gate_s, gate_v, gate_k, gate_q,
         gate_x, err, busy, out_valid};
    for (int k = 0; k < 12; k++) begin
      if (b[k]) begin
        if (first_a[k] < 0) first_a[k] = n;
        last_a[k] = n;
        cnt_a[k]++;
      end
    end
    if (n < 400) begin
      ph_a[n]   = phase;
      row_a[n]  = row_idx;
      col_a[n]  = col_idx;
      bits_a[n] = b;
    end
  endtask

  // One task: burst of 192 (optionally dropped at drop_at), extra in_valid at inj_at/inj_at+1,
  // reset pulse at rst_at; negative values disable the feature.
  task automatic run(input logic [3:0] t, input logic cg, input int drop_at,
                     input int inj_at, input int rst_at, input int ncyc);
    for (int k = 0; k < 12; k++) begin
      first_a[k] = -1;
      last_a[k]  = -1;
      cnt_a[k]   = 0;
    end
    for (int n = 0; n < ncyc; n++) begin
      in_valid = (n < 192 && (drop_at < 0 || n < drop_at))
              || (inj_at >= 0 && (n == inj_at || n == inj_at + 1));
      T        = t;
      cg_en    = cg;
      rst_n    = (n == rst_at);
      @(posedge clk);
      #1;
      sample(n);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
  endtask

  task automatic win(input string tn, input int k, input int lo, input int hi);
    if (lo < 0) begin
      chk($sformatf("%s.%s.count", tn, nm[k]), cnt_a[k], 0);
    end else begin
      chk($sformatf("%s.%s.first", tn, nm[k]), first_a[k], lo);
      chk($sformatf("%s.%s.last", tn, nm[k]), last_a[k], hi);
      chk($sformatf("%s.%s.count", tn, nm[k]), cnt_a[k], hi - lo + 1);
    end
  endtask

  task automatic spot(input string tn, input int n, input phase_t ph,
                      input int row, input int col, input int clr);
    chk($sformatf("%s.c%0d.phase", tn, n), int'(ph_a[n]), int'(ph));
    chk($sformatf("%s.c%0d.row", tn, n), int'(row_a[n]), row);
    chk($sformatf("%s.c%0d.col", tn, n), int'(col_a[n]), col);
    chk($sformatf("%s.c%0d.mac_clr", tn, n), int'(bits_a[n][9]), clr);
  endtask

  initial begin
    rst_n = 1'b1; cg_en = 1'b1; in_valid = 1'b0; T = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.phase", int'(phase), int'(IDLE));
    chk("rst.busy", int'(busy), 0);
    chk("rst.gates_cg1", int'({gate_x, gate_q, gate_k, gate_v, gate_s}), 0);
    chk("rst.idx", int'({row_idx, col_idx}), 0);
    chk("rst.mac_ov_err", int'({mac_clr, mac_en, out_valid, err}), 0);
    cg_en = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.gates_cg0", int'({gate_x, gate_q, gate_k, gate_v, gate_s}), 31);
    rst_n = 1'b0; cg_en = 1'b1;
    @(posedge clk);
    #1;
    chk("idle.busy", int'(busy), 0);

    // T=8 clean task
    run(4'd8, 1'b1, -1, -1, -1, 390);
    win("t8", 0, 320, 383); win("t8", 1, 0, 383); win("t8", 2, -1, 0);
    win("t8", 3, 0, 63);    win("t8", 4, 0, 63);  win("t8", 5, 64, 127);
    win("t8", 6, 128, 191); win("t8", 7, 192, 255); win("t8", 8, 192, 319);
    win("t8", 10, 192, 255); win("t8", 11, 256, 319);
    spot("t8", 0, LD_Q, 0, 0, 0);   spot("t8", 75, LD_K, 1, 3, 0);
    spot("t8", 200, QK, 1, 0, 1);   spot("t8", 201, QK, 1, 1, 0);
    spot("t8", 330, OUT, 1, 2, 0);  spot("t8", 384, IDLE, 0, 0, 0);

    // T=1
    run(4'd1, 1'b1, -1, -1, -1, 215);
    win("t1", 10, 192, 192); win("t1", 11, 193, 200); win("t1", 0, 201, 208);
    win("t1", 3, 0, 7);      win("t1", 1, 0, 208);    win("t1", 2, -1, 0);
    spot("t1", 192, QK, 0, 0, 1); spot("t1", 193, SV, 0, 0, 1); spot("t1", 194, SV, 0, 1, 0);

    // T=4 with gating
    run(4'd4, 1'b1, -1, -1, -1, 280);
    win("t4", 7, 192, 207); win("t4", 6, 128, 191); win("t4", 3, 0, 31);
    win("t4", 0, 240, 271); win("t4", 1, 0, 271);   win("t4", 2, -1, 0);
    spot("t4", 196, QK, 1, 0, 1); spot("t4", 197, QK, 1, 1, 0);
    spot("t4", 216, SV, 1, 0, 1); spot("t4", 217, SV, 1, 1, 0);

    // T=4 without gating, stray in_valid during OUT
    run(4'd4, 1'b0, -1, 250, -1, 280);
    for (int k = 3; k <= 7; k++) win("t4cg0", k, 0, 279);
    win("t4cg0", 2, 251, 252); win("t4cg0", 0, 240, 271);

    // burst dropped at cycle 100, then a clean T=4 task
    run(4'd8, 1'b1, 100, -1, -1, 105);
    win("drop", 2, 101, 101); win("drop", 1, 0, 100); win("drop", 0, -1, 0);
    spot("drop", 100, LD_K, 4, 4, 0); spot("drop", 101, IDLE, 0, 0, 0);
    run(4'd4, 1'b1, -1, -1, -1, 275);
    win("after_drop", 0, 240, 271); win("after_drop", 2, -1, 0);

    // reset mid-task, then back-to-back T=1 tasks
    run(4'd8, 1'b1, -1, -1, 250, 255);
    win("rst_mid", 0, -1, 0); win("rst_mid", 1, 0, 249);
    spot("rst_mid", 249, QK, 7, 1, 0); spot("rst_mid", 250, IDLE, 0, 0, 0);
    chk("rst_mid.c250.flags", int'(bits_a[250]), 0);
    chk("rst_mid.c251.flags", int'(bits_a[251]), 0);
    run(4'd1, 1'b1, -1, -1, -1, 209);
    win("b2b_a", 0, 201, 208); win("b2b_a", 1, 0, 208);
    run(4'd1, 1'b1, -1, -1, -1, 215);
    win("b2b_b", 0, 201, 208); win("b2b_b", 1, 0, 208); win("b2b_b", 2, -1, 0);
    spot("b2b_b", 0, LD_Q, 0, 0, 0);

    // illegal T behaves as 8 with one err pulse
    run(4'd5, 1'b1, -1, -1, -1, 390);
    win("t5", 2, 1, 1); win("t5", 0, 320, 383); win("t5", 10, 192, 255);
    win("t5", 3, 0, 63);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
